// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Two-input round-robin valid/ready arbiter feeding a one-entry output
//   register. o_sel follows the mux2 convention (0 = source A, 1 = source B)
//   and is registered together with the winning word.
//
// Parameters
//   WIDTH       payload width of a, b and y data
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_a_valid   source A has a word
//   i_a_data    source A payload
//   o_a_ready   source A word transfers on this edge when i_a_valid & o_a_ready
//   i_b_valid   source B has a word
//   i_b_data    source B payload
//   o_b_ready   source B word transfers on this edge when i_b_valid & o_b_ready
//   o_y_valid   output register holds a word
//   o_y_data    registered winning word
//   i_y_ready   downstream accepts the output word
//   o_sel       registered source of o_y_data (0 = A, 1 = B)
//   o_cnt_a     saturating count of accepted A words (MUX2_ARB_STATS_EN only)
//   o_cnt_b     saturating count of accepted B words (MUX2_ARB_STATS_EN only)
//
// Optional feature
//   Define MUX2_ARB_STATS_EN to add the o_cnt_a / o_cnt_b transfer counters.

module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a_valid,
  input  logic [WIDTH-1:0] i_a_data,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_b_ready,
  output logic             o_y_valid,
  output logic [WIDTH-1:0] o_y_data,
  input  logic             i_y_ready,
`ifdef MUX2_ARB_STATS_EN
  output logic [15:0]      o_cnt_a,
  output logic [15:0]      o_cnt_b,
`endif
  output logic             o_sel
);

  logic             r_y_valid;
  logic [WIDTH-1:0] r_y_data;
  logic             r_sel;
  logic             r_prio;     // 0: A favoured on a tie, 1: B favoured

  logic             w_load_en;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_grant;

  // Reset is folded into load_en so neither source sees ready while the
  // block is held in reset; otherwise an empty register would advertise ready.
  assign w_load_en = i_rst_n & (~r_y_valid | i_y_ready);

  assign w_grant_a = i_a_valid & (~i_b_valid | ~r_prio);
  assign w_grant_b = i_b_valid & (~i_a_valid |  r_prio);
  assign w_grant   = w_grant_a | w_grant_b;

  assign o_a_ready = w_load_en & w_grant_a;
  assign o_b_ready = w_load_en & w_grant_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
      r_sel     <= 1'b0;
      r_prio    <= 1'b0;
    end else if (w_load_en) begin
      if (w_grant) begin
        r_y_valid <= 1'b1;
        r_y_data  <= w_grant_b ? i_b_data : i_a_data;
        r_sel     <= w_grant_b;
        // Favour the loser next time.
        r_prio    <= ~w_grant_b;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign o_y_valid = r_y_valid;
  assign o_y_data  = r_y_data;
  assign o_sel     = r_sel;

`ifdef MUX2_ARB_STATS_EN
  logic [15:0] r_cnt_a;
  logic [15:0] r_cnt_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (i_a_valid && o_a_ready && (r_cnt_a != 16'hFFFF)) r_cnt_a <= r_cnt_a + 16'd1;
      if (i_b_valid && o_b_ready && (r_cnt_b != 16'hFFFF)) r_cnt_b <= r_cnt_b + 16'd1;
    end
  end

  assign o_cnt_a = r_cnt_a;
  assign o_cnt_b = r_cnt_b;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             sel;
`ifdef MUX2_ARB_STATS_EN
  logic [15:0]      cnt_a;
  logic [15:0]      cnt_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mux2_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_a_valid (a_valid),
    .i_a_data  (a_data),
    .o_a_ready (a_ready),
    .i_b_valid (b_valid),
    .i_b_data  (b_data),
    .o_b_ready (b_ready),
    .o_y_valid (y_valid),
    .o_y_data  (y_data),
    .i_y_ready (y_ready),
`ifdef MUX2_ARB_STATS_EN
    .o_cnt_a   (cnt_a),
    .o_cnt_b   (cnt_b),
`endif
    .o_sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an output slot (full flag, word, source) plus the
  // identity of whoever won most recently. On a tie the source that did not
  // win last is served; after reset B counts as the last winner so A goes first.
  logic             m_full;
  logic [WIDTH-1:0] m_word;
  logic             m_src;
  logic             m_last_b;

  function automatic logic m_can_load();
    return rst_n && (!m_full || y_ready);
  endfunction

  function automatic logic m_take_a();
    return m_can_load() && a_valid && (!b_valid || m_last_b);
  endfunction

  function automatic logic m_take_b();
    return m_can_load() && b_valid && (!a_valid || !m_last_b);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full   = 1'b0;
      m_word   = '0;
      m_src    = 1'b0;
      m_last_b = 1'b1;
    end else begin
      if (m_take_a()) begin
        m_full = 1'b1; m_word = a_data; m_src = 1'b0; m_last_b = 1'b0;
      end else if (m_take_b()) begin
        m_full = 1'b1; m_word = b_data; m_src = 1'b1; m_last_b = 1'b1;
      end else if (m_can_load()) begin
        m_full = 1'b0;
      end
    end
  end

  // Compare process: inputs change just after posedge, so negedge is stable.
  always @(negedge clk) begin
    check("model_a_ready", 32'(a_ready), 32'(m_take_a()));
    check("model_b_ready", 32'(b_ready), 32'(m_take_b()));
    check("model_y_valid", 32'(y_valid), 32'(m_full));
    check("model_y_data",  32'(y_data),  32'(m_word));
    check("model_sel",     32'(sel),     32'(m_src));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    y_ready = 1'b0;

    // 1. Reset with random inputs and clock running
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'($urandom); a_data = 8'($urandom);
      b_valid = 1'($urandom); b_data = 8'($urandom);
      y_ready = 1'($urandom);
      tick();
      check("rst_y_valid", 32'(y_valid), 32'd0);
      check("rst_y_data",  32'(y_data),  32'd0);
      check("rst_sel",     32'(sel),     32'd0);
      check("rst_ready",   32'({a_ready, b_ready}), 32'd0);
    end
    a_valid = 1'b1; a_data = 8'h3C; b_valid = 1'b0; y_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    check("t1_y_valid", 32'(y_valid), 32'd1);
    check("t1_y_data",  32'(y_data),  32'h3C);
    check("t1_sel",     32'(sel),     32'd0);

    // 2. Alternation from reset
    rst_n = 1'b0; #1; rst_n = 1'b1;
    a_valid = 1'b1; a_data = 8'hAA; b_valid = 1'b1; b_data = 8'h55; y_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_y_valid", 32'(y_valid), 32'd1);
      check("t2_y_data",  32'(y_data),  (i % 2 == 0) ? 32'hAA : 32'h55);
      check("t2_sel",     32'(sel),     32'(i % 2));
    end
    tick();
    check("t2_7th_data", 32'(y_data), 32'hAA);

    // 5. Async reset between edges; B would be next without it
    #1; rst_n = 1'b0; #1;
    check("t5_async_y_valid", 32'(y_valid), 32'd0);
    check("t5_async_ready",   32'({a_ready, b_ready}), 32'd0);
    #1; rst_n = 1'b1;
    tick();
    check("t5_first_data", 32'(y_data), 32'hAA);
    check("t5_first_sel",  32'(sel),    32'd0);

    // 3. Back-pressure
    a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b0; y_ready = 1'b1;
    tick();
    check("t3_load_data", 32'(y_data), 32'h11);
    b_valid = 1'b1; b_data = 8'h22; y_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_ready", 32'({a_ready, b_ready}), 32'd0);
      tick();
      check("t3_hold_data",  32'(y_data),  32'h11);
      check("t3_hold_valid", 32'(y_valid), 32'd1);
    end
    y_ready = 1'b1;
    #1;
    check("t3_release_ready", 32'({a_ready, b_ready}), 32'b01);
    tick();
    check("t3_release_data", 32'(y_data), 32'h22);
    check("t3_release_sel",  32'(sel),    32'd1);

    // 4. Single source B
    a_valid = 1'b0; b_valid = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_data = 8'(i);
      tick();
      check("t4_y_valid", 32'(y_valid), 32'd1);
      check("t4_y_data",  32'(y_data),  32'(i));
      check("t4_sel",     32'(sel),     32'd1);
    end
    b_valid = 1'b0;
    tick();
    check("t4_drop_valid", 32'(y_valid), 32'd0);
    check("t4_drop_sel",   32'(sel),     32'd1);

`ifdef MUX2_ARB_STATS_EN
    // 6. Counter saturation
    #1; rst_n = 1'b0; #1; rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b0; y_ready = 1'b1;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b1;
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    b_valid = 1'b0;
    check("t6_cnt_a", 32'(cnt_a), 32'hFFFF);
    check("t6_cnt_b", 32'(cnt_b), 32'd3);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Two-input round-robin stream arbiter that sits directly upstream of mux2. It picks one of two valid/ready sources and registers the winning word into a one-entry output stage. It also drives a registered select that follows the mux2 convention: sel=0 selects a, sel=1 selects b. This gives fair, back-pressured sharing of a single downstream consumer.

Parameters:
WIDTH, 8, data width of a_data, b_data and y_data.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
a_valid  input  1  source A has a word.
a_data  input  WIDTH  source A payload.
a_ready  output  1  A word transfers on a clock edge when a_valid & a_ready.
b_valid  input  1  source B has a word.
b_data  input  WIDTH  source B payload.
b_ready  output  1  B word transfers on a clock edge when b_valid & b_ready.
y_valid  output  1  output register holds a word.
y_data  output  WIDTH  registered winning word.
y_ready  input  1  downstream accepts; transfer when y_valid & y_ready.
sel  output  1  registered source of y_data (0=A, 1=B); feeds mux2 sel.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (immediately on rst_n low, independent of clk):
  - y_valid=0, y_data=0, sel=0.
  - Internal priority pointer prio=0 (A favoured).
- Reset asserted mid-transfer: any held word is discarded; no output until a new grant after release.
- load_en = !y_valid | y_ready (output register empty or draining this cycle).
- Grant, combinational, from current valids and prio:
  - Both valid: winner = prio.
  - Only one valid: winner = that source.
  - Neither valid: no grant.
- Ready outputs:
  - a_ready = load_en & grant_a.
  - b_ready = load_en & grant_b.
  - Never both high in the same cycle.
  - Ready may depend combinationally on the other source's valid and on y_ready. It never depends on the requester's own data.
- On a clock edge with a grant and load_en:
  - y_data <= winner data; y_valid <= 1; sel <= winner.
  - prio <= ~winner, so the loser is favoured next cycle.
- On a clock edge with load_en and no grant:
  - y_valid <= 0.
  - y_data, sel and prio hold.
- On a clock edge with !load_en (y_valid=1, y_ready=0):
  - All registers hold; a_ready=b_ready=0.
- Latency: a word accepted at edge N appears on y_data/y_valid after edge N. Minimum latency 1 cycle.
- Throughput: one word per cycle when y_ready is held high.
- Simultaneous drain and load in one edge is legal and keeps y_valid=1 (full throughput, no bubble).
- Fairness: with both sources continuously valid and y_ready=1, grants alternate A,B,A,B... from reset. The second source never waits more than one transfer.
- sel holds its last value while y_valid=0. It changes only together with a new y_data load.
- No data width conversion; payload passed bit-exact.

Optional Feature:
Macro: MUX2_ARB_STATS_EN
- Defined:
  - Adds output ports cnt_a and cnt_b, each 16 bits.
  - Each counter increments on every accepted transfer from its source (valid & ready at the clock edge).
  - Counters saturate at 16'hFFFF and do not wrap.
  - Both reset to 0 with rst_n.
- Not defined:
  - Ports and counters absent.
  - All other behaviour identical.

Test Plan:
1. Reset: hold rst_n=0 with random inputs and clk running -> y_valid=0, y_data=0, sel=0, a_ready=b_ready=0 throughout. Release with a_valid=1, a_data=8'h3C, y_ready=1 -> after first edge y_valid=1, y_data=8'h3C, sel=0.
2. Alternation: a_valid=b_valid=1 constant, a_data=8'hAA, b_data=8'h55, y_ready=1 for 6 cycles -> y_data sequence AA,55,AA,55,AA,55; sel sequence 0,1,0,1,0,1; no bubbles.
3. Back-pressure: load one A word 8'h11, then y_ready=0 for 4 cycles with both sources valid -> y_data stays 8'h11, a_ready=b_ready=0. Raise y_ready -> next edge loads B (prio flipped), sel=1.
4. Single source: only b_valid=1 with b_data incrementing 0..4, y_ready=1 -> y_data 0,1,2,3,4 back-to-back, sel=1 throughout. Drop b_valid -> y_valid=0 next edge, sel stays 1.
5. Async reset mid-stream: during test 2, pulse rst_n low between clock edges -> y_valid falls immediately without a clock edge. After release, first grant with both valid goes to A.
6. With MUX2_ARB_STATS_EN: 70000 A transfers and 3 B transfers -> cnt_a=16'hFFFF (saturated), cnt_b=3. Without the macro -> bench compiles with no counter ports.
